// File: rtl/wbh_boot_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wbh_boot_seq
//   Power-on / soft-reboot reset and clock sequencer for the wishbone host.
//   Boot order: power wait -> strap load on user_clock1 -> gated clock switch
//   gap -> clocks enabled under system reset -> RUN. A soft reboot returns to
//   the strap window without dropping p_reset_n.
//
//   Optional feature macro: WBH_BOOT_WDOG_EN (RUN-state watchdog that forces a
//   soft reboot when not kicked). Without it, wdog_kick is unused.
//
// Ports
//   mclk          in  reference clock (user_clock1 domain)
//   e_reset_n     in  external reset, async assert, active-low
//   cfg_fast_sim  in  select FAST_DLY instead of PWR_DLY for the power wait
//   soft_boot_req in  1-cycle soft reboot request, honoured in RUN only
//   wdog_kick     in  watchdog restart pulse
//   p_reset_n     out power-on reset to wbh_reg / clock dividers
//   s_reset_n     out soft/system reset
//   clk_enb       out clock gate enable for wbs_clk_out / cpu_clk
//   force_refclk  out force wb clock to user_clock1
//   soft_reboot   out sticky: a soft reboot occurred since e_reset_n
//   boot_done     out high in RUN
// -----------------------------------------------------------------------------
module wbh_boot_seq #(
  parameter logic [15:0] PWR_DLY   = 16'd1024,
  parameter logic [15:0] FAST_DLY  = 16'd4,
  parameter logic [15:0] STRAP_CYC = 16'd8,
  parameter logic [15:0] CLK_GAP   = 16'd4,
  parameter logic [23:0] WDOG_CYC  = 24'hFFFFF
) (
  input  logic mclk,
  input  logic e_reset_n,
  input  logic cfg_fast_sim,
  input  logic soft_boot_req,
  input  logic wdog_kick,
  output logic p_reset_n,
  output logic s_reset_n,
  output logic clk_enb,
  output logic force_refclk,
  output logic soft_reboot,
  output logic boot_done
);

  typedef enum logic [2:0] {
    S_WAIT_PWR,
    S_STRAP,
    S_GAP,
    S_CLKON,
    S_RUN,
    S_SRST
  } state_t;

  // A state of length N holds the counter at N-1; N=0 behaves as N=1.
  function automatic logic [15:0] f_load(input logic [15:0] n);
    return (n == '0) ? '0 : n - 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Reset synchroniser: async assert, release on the 2nd mclk edge.
  // ---------------------------------------------------------------------------
  logic [1:0] r_sync;
  logic       w_rst_n;

  always_ff @(posedge mclk or negedge e_reset_n) begin
    if (!e_reset_n) r_sync <= '0;
    else            r_sync <= {r_sync[0], 1'b1};
  end

  assign w_rst_n = r_sync[1];

  // ---------------------------------------------------------------------------
  // State, counter and registered outputs
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_pwr_load;
  logic        w_cnt_zero;
  logic        w_run_exit;
  logic        w_srst_entry;

  logic r_p_reset_n, r_s_reset_n, r_clk_enb, r_force_refclk, r_soft_reboot, r_boot_done;
  logic w_p_nxt, w_s_nxt, w_clk_nxt, w_force_nxt, w_done_nxt;

  assign w_pwr_load   = cfg_fast_sim ? f_load(FAST_DLY) : f_load(PWR_DLY);
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_srst_entry = (r_state == S_RUN) && (w_state_nxt == S_SRST);

  // The counter keeps reloading the power wait while the synchroniser holds
  // the FSM in reset, so cfg_fast_sim is captured on the releasing edge and
  // the first WAIT_PWR cycle already counts.
  always_ff @(posedge mclk or negedge e_reset_n) begin
    if (!e_reset_n)    r_cnt <= f_load(PWR_DLY);
    else if (!w_rst_n) r_cnt <= w_pwr_load;
    else               r_cnt <= w_cnt_nxt;
  end

  always_ff @(posedge mclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state        <= S_WAIT_PWR;
      r_p_reset_n    <= 1'b0;
      r_s_reset_n    <= 1'b0;
      r_clk_enb      <= 1'b0;
      r_force_refclk <= 1'b1;
      r_soft_reboot  <= 1'b0;
      r_boot_done    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_p_reset_n    <= w_p_nxt;
      r_s_reset_n    <= w_s_nxt;
      r_clk_enb      <= w_clk_nxt;
      r_force_refclk <= w_force_nxt;
      r_soft_reboot  <= r_soft_reboot | w_srst_entry;
      r_boot_done    <= w_done_nxt;
    end
  end

  // Next state and counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 16'd1;
    case (r_state)
      S_WAIT_PWR: if (w_cnt_zero) begin
        w_state_nxt = S_STRAP;
        w_cnt_nxt   = f_load(STRAP_CYC);
      end
      S_STRAP, S_SRST: if (w_cnt_zero) begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = f_load(CLK_GAP);
      end
      S_GAP: if (w_cnt_zero) begin
        w_state_nxt = S_CLKON;
        w_cnt_nxt   = f_load(CLK_GAP);
      end
      S_CLKON: if (w_cnt_zero) begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt;
        if (w_run_exit) begin
          w_state_nxt = S_SRST;
          w_cnt_nxt   = f_load(STRAP_CYC);
        end
      end
      default: begin
        w_state_nxt = S_WAIT_PWR;
        w_cnt_nxt   = f_load(PWR_DLY);
      end
    endcase
  end

  // Outputs decoded from the next state so they move on the transition edge
  always_comb begin
    w_p_nxt     = 1'b1;
    w_s_nxt     = 1'b0;
    w_clk_nxt   = 1'b0;
    w_force_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      S_WAIT_PWR: begin
        w_p_nxt     = 1'b0;
        w_force_nxt = 1'b1;
      end
      S_STRAP, S_SRST: w_force_nxt = 1'b1;
      S_GAP:   ;
      S_CLKON: w_clk_nxt = 1'b1;
      S_RUN: begin
        w_s_nxt    = 1'b1;
        w_clk_nxt  = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_p_nxt     = 1'b0;
        w_force_nxt = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RUN exit conditions
  // ---------------------------------------------------------------------------
`ifdef WBH_BOOT_WDOG_EN
  logic [23:0] r_wd_cnt;
  logic [23:0] w_wd_load;
  logic        w_wd_expire;

  assign w_wd_load   = (WDOG_CYC == '0) ? '0 : WDOG_CYC - 24'd1;
  // A kick in the expiry cycle wins; a concurrent soft request merges into
  // the same single SRST entry.
  assign w_wd_expire = (r_state == S_RUN) && (r_wd_cnt == '0) && !wdog_kick;
  assign w_run_exit  = soft_boot_req || w_wd_expire;

  always_ff @(posedge mclk or negedge w_rst_n) begin
    if (!w_rst_n)
      r_wd_cnt <= w_wd_load;
    else if ((w_state_nxt == S_RUN) && ((r_state != S_RUN) || wdog_kick))
      r_wd_cnt <= w_wd_load;
    else if ((r_state == S_RUN) && (r_wd_cnt != '0))
      r_wd_cnt <= r_wd_cnt - 24'd1;
  end
`else
  logic w_unused_wdog;

  assign w_run_exit    = soft_boot_req;
  assign w_unused_wdog = ^{wdog_kick, WDOG_CYC};
`endif

  assign p_reset_n    = r_p_reset_n;
  assign s_reset_n    = r_s_reset_n;
  assign clk_enb      = r_clk_enb;
  assign force_refclk = r_force_refclk;
  assign soft_reboot  = r_soft_reboot;
  assign boot_done    = r_boot_done;

endmodule

// File: tb/tb_wbh_boot_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_wbh_boot_seq
//   Self-checking bench for wbh_boot_seq. Each scenario pushes the expected
//   output vector {p_reset_n, s_reset_n, clk_enb, force_refclk, soft_reboot,
//   boot_done} for every mclk edge of a timeline into a scoreboard, then pops
//   and compares as the DUT produces outputs.
// -----------------------------------------------------------------------------
module tb_wbh_boot_seq;

  localparam logic [5:0] V_WAIT  = 6'b000100;
  localparam logic [5:0] V_STRAP = 6'b100100;
  localparam logic [5:0] V_GAP   = 6'b100000;
  localparam logic [5:0] V_CLKON = 6'b101000;
  localparam logic [5:0] V_RUN   = 6'b111001;
  localparam logic [5:0] V_SRST  = 6'b100110;
  localparam logic [5:0] SOFT    = 6'b000010;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  val;
  } exp_t;

  logic mclk = 1'b0;
  logic e_reset_n = 1'b0;
  logic cfg_fast_sim = 1'b1;
  logic soft_boot_req = 1'b0;
  logic wdog_kick = 1'b0;
  logic p_reset_n, s_reset_n, clk_enb, force_refclk, soft_reboot, boot_done;
  logic [5:0] w_out;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t sb[$];

  wbh_boot_seq #(
    .PWR_DLY  (16'd1024),
    .FAST_DLY (16'd4),
    .STRAP_CYC(16'd8),
    .CLK_GAP  (16'd4),
    .WDOG_CYC (24'd16)
  ) dut (
    .mclk         (mclk),
    .e_reset_n    (e_reset_n),
    .cfg_fast_sim (cfg_fast_sim),
    .soft_boot_req(soft_boot_req),
    .wdog_kick    (wdog_kick),
    .p_reset_n    (p_reset_n),
    .s_reset_n    (s_reset_n),
    .clk_enb      (clk_enb),
    .force_refclk (force_refclk),
    .soft_reboot  (soft_reboot),
    .boot_done    (boot_done)
  );

  assign w_out = {p_reset_n, s_reset_n, clk_enb, force_refclk, soft_reboot, boot_done};

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  // Expected value v on edges base+from .. base+to
  task automatic push_seg(input int unsigned base, input int unsigned from,
                          input int unsigned to, input logic [5:0] v);
    exp_t e;
    for (int unsigned k = from; k <= to; k++) begin
      e.cyc = base + k;
      e.val = v;
      sb.push_back(e);
    end
  endtask

  // Cold boot after e_reset_n release: 2 sync edges overlap the power wait d
  task automatic push_boot(input int unsigned base, input int unsigned d,
                           input int unsigned last);
    push_seg(base, 1,      d + 1,  V_WAIT);
    push_seg(base, d + 2,  d + 9,  V_STRAP);
    push_seg(base, d + 10, d + 13, V_GAP);
    push_seg(base, d + 14, d + 17, V_CLKON);
    push_seg(base, d + 18, last,   V_RUN);
  endtask

  // Soft reboot timeline starting at the edge that samples the request
  task automatic push_srst(input int unsigned base, input int unsigned last);
    push_seg(base, 1,  8,    V_SRST);
    push_seg(base, 9,  12,   V_GAP   | SOFT);
    push_seg(base, 13, 16,   V_CLKON | SOFT);
    push_seg(base, 17, last, V_RUN   | SOFT);
  endtask

  task automatic do_release(input logic fast, output int unsigned base);
    @(negedge mclk);
    e_reset_n = 1'b0;
    repeat (3) @(negedge mclk);
    cfg_fast_sim = fast;
    base = cyc;
    e_reset_n = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge mclk);
    n_cmp++;
    if (w_out !== V_WAIT) begin
      n_err++;
      $display("FAIL reset_values got=%b exp=%b", w_out, V_WAIT);
    end
  endtask

  task automatic test_fast_boot;
    int unsigned base, guard;
    exp_t e;
    do_release(1'b1, base);
    push_boot(base, 4, 30);
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge mclk); #1; guard++;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (e.cyc != cyc || w_out !== e.val) begin
          n_err++;
          $display("FAIL fast_boot k=%0d got=%b exp=%b", e.cyc - base, w_out, e.val);
        end
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL fast_boot timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_ignored_req;
    int unsigned base, guard, k;
    exp_t e;
    do_release(1'b1, base);
    push_boot(base, 4, 26);
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge mclk); #1; guard++;
      k = cyc - base;
      if (k == 8) soft_boot_req = 1'b1;   // sampled on edge 9, inside STRAP
      if (k == 9) soft_boot_req = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (e.cyc != cyc || w_out !== e.val) begin
          n_err++;
          $display("FAIL ignored_req k=%0d got=%b exp=%b", e.cyc - base, w_out, e.val);
        end
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL ignored_req timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  // Entered in RUN; request held two edges so the second sample lands in SRST
  task automatic test_soft_reboot;
    int unsigned base, guard, k;
    exp_t e;
    @(negedge mclk);
    base = cyc;
    soft_boot_req = 1'b1;
    push_srst(base, 24);
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge mclk); #1; guard++;
      k = cyc - base;
      if (k == 2) soft_boot_req = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (e.cyc != cyc || w_out !== e.val) begin
          n_err++;
          $display("FAIL soft_reboot k=%0d got=%b exp=%b", e.cyc - base, w_out, e.val);
        end
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL soft_reboot timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  // Entered in RUN with soft_reboot=1; reset hits during the CLKON phase
  task automatic test_mid_reset;
    int unsigned base, guard, k;
    exp_t e;
    @(negedge mclk);
    base = cyc;
    soft_boot_req = 1'b1;
    push_seg(base, 1,  8,  V_SRST);
    push_seg(base, 9,  12, V_GAP   | SOFT);
    push_seg(base, 13, 14, V_CLKON | SOFT);
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge mclk); #1; guard++;
      k = cyc - base;
      if (k == 1) soft_boot_req = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (e.cyc != cyc || w_out !== e.val) begin
          n_err++;
          $display("FAIL mid_reset k=%0d got=%b exp=%b", e.cyc - base, w_out, e.val);
        end
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL mid_reset timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
    // Assert between edges: outputs must fall back without any mclk edge
    #2 e_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (w_out !== V_WAIT) begin
      n_err++;
      $display("FAIL mid_reset_async got=%b exp=%b", w_out, V_WAIT);
    end
    do_release(1'b1, base);
    push_boot(base, 4, 26);
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge mclk); #1; guard++;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (e.cyc != cyc || w_out !== e.val) begin
          n_err++;
          $display("FAIL mid_reset_reboot k=%0d got=%b exp=%b", e.cyc - base, w_out, e.val);
        end
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL mid_reset_reboot timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  // cfg_fast_sim flips mid-wait and must not shorten the 1024-cycle wait
  task automatic test_normal_boot;
    int unsigned base, guard, k;
    exp_t e;
    do_release(1'b0, base);
    push_boot(base, 1024, 1024 + 22);
    guard = 0;
    while (sb.size() != 0 && guard < 1200) begin
      @(posedge mclk); #1; guard++;
      k = cyc - base;
      if (k == 3) cfg_fast_sim = 1'b1;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (e.cyc != cyc || w_out !== e.val) begin
          n_err++;
          $display("FAIL normal_boot k=%0d got=%b exp=%b", e.cyc - base, w_out, e.val);
        end
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL normal_boot timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  // RUN entered on edge 22. Phase A: no kick. Phase B: kick every 10 cycles.
  task automatic test_wdog;
    int unsigned base, guard, k;
    exp_t e;
    do_release(1'b1, base);
`ifdef WBH_BOOT_WDOG_EN
    push_boot(base, 4, 37);
    push_srst(base + 37, 60 - 37);
`else
    push_boot(base, 4, 60);
`endif
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge mclk); #1; guard++;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (e.cyc != cyc || w_out !== e.val) begin
          n_err++;
          $display("FAIL wdog_nokick k=%0d got=%b exp=%b", e.cyc - base, w_out, e.val);
        end
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL wdog_nokick timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
    do_release(1'b1, base);
    push_boot(base, 4, 65);
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge mclk); #1; guard++;
      k = cyc - base;
      wdog_kick = (k == 25 || k == 35 || k == 45 || k == 55);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (e.cyc != cyc || w_out !== e.val) begin
          n_err++;
          $display("FAIL wdog_kick k=%0d got=%b exp=%b", e.cyc - base, w_out, e.val);
        end
      end
    end
    wdog_kick = 1'b0;
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL wdog_kick timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_fast_boot();
    test_soft_reboot();
    test_ignored_req();
    test_soft_reboot();
    test_mid_reset();
    test_normal_boot();
    test_wdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
